seg7_page_display: RTL

- Parametrised successor to the fixed four-digit, switch-selected 7-segment display logic on the Cyclone II starter board.
- Holds PAGES pages of DIGITS glyph codes each, for example hh:mm, ss, weekday+day, and yy:mm.
- Selects one page by one-hot priority request, by timed auto-rotation, or by a default page. Supports per-digit blinking for time-setting.
- Drives either static per-digit active-low segments, or a time-multiplexed segment bus with a digit strobe.

---
 rtl/seg7_page_display_pkg.sv | 92 +++++++++
 rtl/seg7_page_display_scan.sv | 51 +++++
 rtl/seg7_page_display.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg7_page_display_pkg.sv
// Shared types for the paged 7-segment display: glyph codes, the glyph-to-
// segment table, the weekday glyph helper and the page-select mode encoding.
package seg7_page_display_pkg;

    typedef logic [4:0] glyph_t;

    // Page-select mode, derived combinationally from sel and auto_rotate.
    typedef enum logic [1:0] {
        MODE_DEFAULT = 2'd0,
        MODE_ROTATE  = 2'd1,
        MODE_MANUAL  = 2'd2
    } page_mode_e;

    // Codes 0..15 are the hex digits; 16..31 are letters and symbols.
    localparam glyph_t GLYPH_DASH  = 5'd16;
    localparam glyph_t GLYPH_BLANK = 5'd17;
    localparam glyph_t GLYPH_M     = 5'd18;
    localparam glyph_t GLYPH_o     = 5'd19;
    localparam glyph_t GLYPH_t     = 5'd20;
    localparam glyph_t GLYPH_u     = 5'd21;
    localparam glyph_t GLYPH_W     = 5'd22;
    localparam glyph_t GLYPH_E     = 5'd23;
    localparam glyph_t GLYPH_h     = 5'd24;
    localparam glyph_t GLYPH_F     = 5'd25;
    localparam glyph_t GLYPH_r     = 5'd26;
    localparam glyph_t GLYPH_S     = 5'd27;
    localparam glyph_t GLYPH_A     = 5'd28;
    localparam glyph_t GLYPH_d     = 5'd29;
    localparam glyph_t GLYPH_n     = 5'd30;
    localparam glyph_t GLYPH_P     = 5'd31;

    // Active-low GFEDCBA pattern for a glyph code. The table is written
    // active-high (lit = 1) for readability and inverted on return.
    function automatic logic [6:0] glyph_seg(input glyph_t code);
        logic [6:0] lit;
        lit = 7'h00;
        case (code)
            5'd0:  lit = 7'h3F;
            5'd1:  lit = 7'h06;
            5'd2:  lit = 7'h5B;
            5'd3:  lit = 7'h4F;
            5'd4:  lit = 7'h66;
            5'd5:  lit = 7'h6D;
            5'd6:  lit = 7'h7D;
            5'd7:  lit = 7'h07;
            5'd8:  lit = 7'h7F;
            5'd9:  lit = 7'h6F;
            5'd10: lit = 7'h77;
            5'd11: lit = 7'h7C;
            5'd12: lit = 7'h39;
            5'd13: lit = 7'h5E;
            5'd14: lit = 7'h79;
            5'd15: lit = 7'h71;
            5'd16: lit = 7'h40; // dash
            5'd17: lit = 7'h00; // blank
            5'd18: lit = 7'h37; // M (wide n)
            5'd19: lit = 7'h5C; // o
            5'd20: lit = 7'h78; // t
            5'd21: lit = 7'h1C; // u
            5'd22: lit = 7'h2A; // W (b, d, f)
            5'd23: lit = 7'h79; // E
            5'd24: lit = 7'h74; // h
            5'd25: lit = 7'h71; // F
            5'd26: lit = 7'h50; // r
            5'd27: lit = 7'h6D; // S
            5'd28: lit = 7'h77; // A
            5'd29: lit = 7'h5E; // d
            5'd30: lit = 7'h54; // n
            5'd31: lit = 7'h73; // P
        endcase
        return ~lit;
    endfunction

    // Two-letter weekday abbreviation, {left glyph, right glyph}.
    // 0 = Su, 1 = Mo, 2 = tu, 3 = WE, 4 = th, 5 = Fr, 6 = SA; 7 shows dashes.
    function automatic logic [9:0] week_day_glyphs(input logic [2:0] day_of_week);
        logic [9:0] g;
        g = {GLYPH_DASH, GLYPH_DASH};
        case (day_of_week)
            3'd0: g = {GLYPH_S, GLYPH_u};
            3'd1: g = {GLYPH_M, GLYPH_o};
            3'd2: g = {GLYPH_t, GLYPH_u};
            3'd3: g = {GLYPH_W, GLYPH_E};
            3'd4: g = {GLYPH_t, GLYPH_h};
            3'd5: g = {GLYPH_F, GLYPH_r};
            3'd6: g = {GLYPH_S, GLYPH_A};
            default: g = {GLYPH_DASH, GLYPH_DASH};
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_page_display_scan.sv
// Digit scanner: walks a digit index every SCAN_DIV clocks and registers the
// matching segment slice together with its strobe so the two stay aligned.
module seg7_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 24000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGITS*7-1:0] seg,
    output logic [6:0]          seg_mux,
    output logic [DIGITS-1:0]   dig_sel_n
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [6:0]        seg_mux_q, seg_mux_d;
    logic [DIGITS-1:0] dig_sel_n_q, dig_sel_n_d;

    // Slot timer, digit index, and the aligned segment/strobe pair.
    always_comb begin
        scan_cnt_d  = scan_cnt_q + CNT_W'(1);
        scan_idx_d  = scan_idx_q;
        if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end
        seg_mux_d   = seg[int'(scan_idx_q) * 7 +: 7];
        dig_sel_n_d = ~(DIGITS'(1) << scan_idx_q);
    end

    // Scanner registers; reset strobes digit 0 with a blank pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            seg_mux_q   <= 7'h7F;
            dig_sel_n_q <= ~DIGITS'(1);
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            seg_mux_q   <= seg_mux_d;
            dig_sel_n_q <= dig_sel_n_d;
        end
    end

    assign seg_mux   = seg_mux_q;
    assign dig_sel_n = dig_sel_n_q;

endmodule

// File: rtl/seg7_page_display.sv
// Paged 7-segment display: picks one of PAGES glyph pages (manual request,
// timed rotation or default page), applies digit blinking, decodes glyphs to
// static segments and feeds the multiplexed scanner.
module seg7_page_display
    import seg7_page_display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PAGES        = 4,
    parameter int ROTATE_TICKS = 300,
    parameter int BLINK_TICKS  = 50,
    parameter int SCAN_DIV     = 24000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic [PAGES*DIGITS*5-1:0]   page_data,
    input  logic [PAGES-1:0]            sel,
    input  logic                        auto_rotate,
    input  logic [DIGITS-1:0]           blink_mask,
    output logic [DIGITS*7-1:0]         seg,
    output logic [6:0]                  seg_mux,
    output logic [DIGITS-1:0]           dig_sel_n,
    output logic [$clog2(PAGES)-1:0]    page
);
    localparam int PAGE_W = $clog2(PAGES);
    localparam int ROT_W  = $clog2(ROTATE_TICKS + 1);
    localparam int BL_W   = $clog2(BLINK_TICKS + 1);

    page_mode_e         mode;
    logic [PAGE_W-1:0]  sel_idx;
    logic [PAGE_W-1:0]  page_q, page_d;
    logic [ROT_W-1:0]   rot_cnt_q, rot_cnt_d;
    logic [BL_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [DIGITS*7-1:0] seg_q, seg_d;

    // Mode and lowest-set request bit; scanning downward lets the lowest bit win.
    always_comb begin
        sel_idx = '0;
        for (int i = PAGES - 1; i >= 0; i--) begin
            if (sel[i]) sel_idx = PAGE_W'(i);
        end
        if (sel != '0)       mode = MODE_MANUAL;
        else if (auto_rotate) mode = MODE_ROTATE;
        else                 mode = MODE_DEFAULT;
    end

    // Next page and rotation counter; rotation continues from the held page.
    always_comb begin
        page_d    = PAGE_W'(PAGES - 1);
        rot_cnt_d = '0;
        case (mode)
            MODE_MANUAL: begin
                page_d = sel_idx;
            end
            MODE_ROTATE: begin
                page_d    = page_q;
                rot_cnt_d = rot_cnt_q;
                if (clk_en) begin
                    if (rot_cnt_q == ROT_W'(ROTATE_TICKS - 1)) begin
                        rot_cnt_d = '0;
                        page_d    = (page_q == PAGE_W'(PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
                    end else begin
                        rot_cnt_d = rot_cnt_q + ROT_W'(1);
                    end
                end
            end
            default: begin
                page_d    = PAGE_W'(PAGES - 1);
                rot_cnt_d = '0;
            end
        endcase
    end

    // Free-running blink timer toggling the phase every BLINK_TICKS ticks.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (clk_en) begin
            if (blink_cnt_q == BL_W'(BLINK_TICKS - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
        end
    end

    // Decode the displayed page, blanking masked digits in the blink-off phase.
    always_comb begin
        seg_d = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (blink_phase_q && blink_mask[d])
                seg_d[d*7 +: 7] = 7'h7F;
            else
                seg_d[d*7 +: 7] = glyph_seg(page_data[(int'(page_q) * DIGITS + d) * 5 +: 5]);
        end
    end

    // State registers; reset lands on the default page with everything blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_q        <= PAGE_W'(PAGES - 1);
            rot_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= '1;
        end else begin
            page_q        <= page_d;
            rot_cnt_q     <= rot_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
        end
    end

    assign seg  = seg_q;
    assign page = page_q;

    seg7_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg_q),
        .seg_mux   (seg_mux),
        .dig_sel_n (dig_sel_n)
    );

endmodule
